// File: rtl/slave_rd_arbiter.sv
// Round-robin read arbiter in front of slave_device: one packet (2 header bytes + LEN payload) per grant.
// Optional header sequence checking is built when the HDR_CHECK_EN macro is defined.
module slave_rd_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_LEN  = 254,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned HDR_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic [1:0]        req,
   input  logic [7:0]        req_len0,
   input  logic [7:0]        req_len1,
   output logic [1:0]        gnt,
   output logic              ram_rd_rq,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_valid,
   output logic              rsp_last,
   output logic              busy,
   output logic              hdr_err
);

   localparam logic [7:0] MaxLen = 8'((MAX_LEN > 255) ? 255 : MAX_LEN);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [7:0]        len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;

   logic              issue, issue_last, beat, beat_last;
   logic [ADDR_W-1:0] last_addr;
   logic [1:0]        win;
   logic [7:0]        sel_len;

   assign last_addr  = ADDR_W'(len_q) + ADDR_W'(1);
   assign issue      = (state_q == StIssue);
   assign issue_last = issue && (cnt_q == last_addr);
   assign beat       = vld_pipe_q[RD_LAT-1];
   assign beat_last  = beat & last_pipe_q[RD_LAT-1];

   // On a tie rr_ptr_q names the requester that goes first.
   always_comb begin
      win = 2'b00;
      unique case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = rr_ptr_q ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
   end

   assign sel_len = win[1] ? req_len1 : req_len0;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               gnt_d   = win;
               len_d   = (sel_len > MaxLen) ? MaxLen : sel_len;
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (issue_last) state_d = StDrain;
         end
         StDrain: begin
            if (beat_last) begin
               gnt_d    = 2'b00;
               rr_ptr_d = gnt_q[0];
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= StIdle;
         gnt_q    <= 2'b00;
         len_q    <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Return-path tags travel RD_LAT stages so they line up with data_i.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
      end else begin
         vld_pipe_q[0]  <= issue;
         last_pipe_q[0] <= issue_last;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            last_pipe_q[i] <= last_pipe_q[i-1];
         end
      end
   end

   assign ram_rd_rq = issue;
   assign rd_addr   = issue ? cnt_q : '0;
   assign gnt       = gnt_q;
   assign rsp_valid = {2{beat}} & gnt_q;
   assign rsp_last  = beat_last;
   assign rsp_data  = beat ? data_i : '0;
   assign busy      = (state_q != StIdle);

`ifdef HDR_CHECK_EN
   localparam int unsigned HdrW = 2 * DATA_W;

   logic [1:0]        bidx_q;
   logic [DATA_W-1:0] hdr_hi_q;
   logic [HdrW-1:0]   hdr_prev_q;
   logic              hdr_seen_q;
   logic [HdrW-1:0]   hdr_cur;

   assign hdr_cur = {hdr_hi_q, data_i};

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         bidx_q     <= 2'd0;
         hdr_hi_q   <= '0;
         hdr_prev_q <= '0;
         hdr_seen_q <= 1'b0;
      end else begin
         if (state_q == StIdle) begin
            bidx_q <= 2'd0;
         end else if (beat && (bidx_q != 2'd2)) begin
            bidx_q <= bidx_q + 2'd1;
         end
         if (beat && (bidx_q == 2'd0)) hdr_hi_q <= data_i;
         if (beat && (bidx_q == 2'd1)) begin
            hdr_prev_q <= hdr_cur;
            hdr_seen_q <= 1'b1;
         end
      end
   end

   assign hdr_err = beat && (bidx_q == 2'd1) && hdr_seen_q &&
                    (hdr_cur != hdr_prev_q + HdrW'(HDR_STEP));
`else
   logic unused_hdr_step;
   assign unused_hdr_step = ^HDR_STEP;
   assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_rd_arbiter.sv
// Scoreboard bench for slave_rd_arbiter: a behavioural slave feeds data_i, expected
// addresses and beats are queued when packets are requested and popped as the DUT responds.
module tb_slave_rd_arbiter;

   localparam int RdLat = 2;

   logic        clk = 1'b0;
   logic        rst_l;
   logic [1:0]  req = 2'b00;
   logic [7:0]  req_len0 = 8'd0;
   logic [7:0]  req_len1 = 8'd0;
   logic [1:0]  gnt;
   logic        ram_rd_rq;
   logic [15:0] rd_addr;
   logic [7:0]  data_i;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_valid;
   logic        rsp_last;
   logic        busy;
   logic        hdr_err;

   slave_rd_arbiter dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .req       (req),
      .req_len0  (req_len0),
      .req_len1  (req_len1),
      .gnt       (gnt),
      .ram_rd_rq (ram_rd_rq),
      .rd_addr   (rd_addr),
      .data_i    (data_i),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .rsp_last  (rsp_last),
      .busy      (busy),
      .hdr_err   (hdr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] v;
      logic [7:0] d;
      logic       l;
      logic       e;
      int         idx;
   } beat_t;

   beat_t       bq[$];
   logic [15:0] aq[$];
   logic [15:0] hdr_val = 16'h1234;
   logic        m_seen = 1'b0;
   logic [15:0] m_prev = 16'h0000;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          issue0_cyc = 0;
   int          n_hdr_err = 0;
   logic [7:0]  s0 = 8'h00;
   logic [7:0]  s1 = 8'h00;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      if (a == 16'd0) return hdr_val[15:8];
      if (a == 16'd1) return hdr_val[7:0];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Slave model: byte for an address issued in cycle t is on data_i during cycle t+2.
   always @(posedge clk) begin
      s0  <= ram_rd_rq ? mem_byte(rd_addr) : 8'h00;
      s1  <= s0;
      cyc <= cyc + 1;
   end
   assign data_i = s1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_pkt(input int who, input int len_req);
      int    len;
      beat_t b;
      len = (len_req > 254) ? 254 : len_req;
      for (int a = 0; a <= len + 1; a++) begin
         aq.push_back(16'(a));
         b.v   = (who != 0) ? 2'b10 : 2'b01;
         b.d   = mem_byte(16'(a));
         b.l   = (a == len + 1);
         b.e   = 1'b0;
         b.idx = a;
`ifdef HDR_CHECK_EN
         if (a == 1) begin
            b.e    = m_seen && (hdr_val != m_prev + 16'd1);
            m_seen = 1'b1;
            m_prev = hdr_val;
         end
`endif
         bq.push_back(b);
      end
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n = 0;
      while (busy !== lvl && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy !== lvl) check_eq(tag, 32'(busy), 32'(lvl));
   endtask

   task automatic end_checks(input string tag);
      check_eq({tag, "_addr_left"}, 32'(aq.size()), 0);
      check_eq({tag, "_beat_left"}, 32'(bq.size()), 0);
      check_eq({tag, "_gnt_idle"}, 32'(gnt), 0);
      check_eq({tag, "_busy_idle"}, 32'(busy), 0);
   endtask

   task automatic run_single(input logic [1:0] r, input string tag);
      req = r;
      wait_busy(1'b1, {tag, "_start"});
      req      = 2'b00;
      req_len0 = 8'd200;
      req_len1 = 8'd200;
      wait_busy(1'b0, {tag, "_end"});
      end_checks(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_gnt"}, 32'(gnt), 0);
      check_eq({tag, "_rq"}, 32'(ram_rd_rq), 0);
      check_eq({tag, "_addr"}, 32'(rd_addr), 0);
      check_eq({tag, "_valid"}, 32'(rsp_valid), 0);
      check_eq({tag, "_last"}, 32'(rsp_last), 0);
      check_eq({tag, "_data"}, 32'(rsp_data), 0);
      check_eq({tag, "_hdr_err"}, 32'(hdr_err), 0);
   endtask

   // Monitor: compares every issued address and every returned beat against the queues.
   initial begin
      logic  prev_rq = 1'b0;
      beat_t b;
      forever begin
         @(negedge clk);
         if (ram_rd_rq) begin
            if (rd_addr == 16'd0) begin
               check_eq("idle_gap", 32'(prev_rq), 0);
               issue0_cyc = cyc;
            end
            check_eq("addr_expected", 32'(aq.size() != 0), 1);
            if (aq.size() != 0) check_eq("rd_addr", 32'(rd_addr), 32'(aq.pop_front()));
         end
         prev_rq = ram_rd_rq;
         if (hdr_err) n_hdr_err++;
         if (rsp_valid != 2'b00) begin
            check_eq("beat_expected", 32'(bq.size() != 0), 1);
            if (bq.size() != 0) begin
               b = bq.pop_front();
               check_eq("rsp_valid", 32'(rsp_valid), 32'(b.v));
               check_eq("rsp_data", 32'(rsp_data), 32'(b.d));
               check_eq("rsp_last", 32'(rsp_last), 32'(b.l));
               check_eq("hdr_err", 32'(hdr_err), 32'(b.e));
               if (b.idx == 0) check_eq("first_beat_latency", 32'(cyc - issue0_cyc), RdLat);
            end
         end else if (rsp_last || hdr_err) begin
            check_eq("stray_flags", {30'd0, rsp_last, hdr_err}, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_l = 1'b1;
      #1 rst_l = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_l = 1'b1;
      @(negedge clk);

      // Tie from reset: req0, req1, then req0 again.
      req_len0 = 8'd1;
      req_len1 = 8'd1;
      push_pkt(0, 1);
      push_pkt(1, 1);
      push_pkt(0, 1);
      req = 2'b11;
      repeat (3) begin
         wait_busy(1'b1, "tie_start");
         wait_busy(1'b0, "tie_end");
      end
      req = 2'b00;
      end_checks("tie");

      req_len0 = 8'd3;
      push_pkt(0, 3);
      run_single(2'b01, "len3");

      req_len1 = 8'd0;
      push_pkt(1, 0);
      run_single(2'b10, "len0");

      req_len0 = 8'd255;
      push_pkt(0, 255);
      run_single(2'b01, "clamp");

      // Abort mid-issue, then a fresh packet must restart at address 0.
      req_len0 = 8'd10;
      push_pkt(0, 10);
      req = 2'b01;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (ram_rd_rq && rd_addr == 16'd2) break;
      end
      check_eq("abort_reached_addr2", 32'(rd_addr), 2);
      #2 rst_l = 1'b0;
      #1 check_all_zero("abort");
      aq.delete();
      bq.delete();
      m_seen = 1'b0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      req_len0 = 8'd2;
      push_pkt(0, 2);
      run_single(2'b01, "after_abort");

`ifdef HDR_CHECK_EN
      rst_l = 1'b0;
      m_seen = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      n_hdr_err = 0;
      req_len0 = 8'd1;
      hdr_val = 16'h0005;
      push_pkt(0, 1);
      run_single(2'b01, "hdr5");
      hdr_val  = 16'h0006;
      req_len0 = 8'd1;
      push_pkt(0, 1);
      run_single(2'b01, "hdr6");
      check_eq("hdr_no_err_yet", 32'(n_hdr_err), 0);
      hdr_val  = 16'h0009;
      req_len0 = 8'd1;
      push_pkt(0, 1);
      run_single(2'b01, "hdr9");
      check_eq("hdr_err_pulses", 32'(n_hdr_err), 1);
`else
      check_eq("hdr_err_never", 32'(n_hdr_err), 0);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
